mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: number of consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have port req  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_req_in  input  1  fetch-side request.
REQ-005 SHALL have port instr_addr_in  input  32  fetch byte address.
REQ-006 SHALL have port instr_gnt_o  output  1  fetch request accepted.
REQ-007 SHALL have port instr_rvalid_o  output  1  fetch response valid.
REQ-008 SHALL have port instr_rdata_o  output  32  fetch read data.
REQ-009 SHALL have port data_req_in  input  1  LSU-side request.
REQ-010 SHALL have ports data_add_in (input 32), data_we_in (input 1), data_be_in (input 4) and data_wdata_in (input 32): LSU address, write enable, byte enables and write data.
REQ-011 SHALL have ports data_gnt_o (output 1), data_rvalid_o (output 1) and data_rdata_o (output 32): LSU grant, response valid and read data.
REQ-012 SHALL have ports mem_req_o (output 1), mem_add_o (output 32), mem_we_o (output 1), mem_be_o (output 4) and mem_wdata_o (output 32): the shared memory request.
REQ-013 SHALL have ports mem_gnt_in (input 1), mem_rvalid_in (input 1) and mem_rdata_in (input 32): the shared memory grant, response valid and read data.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY_I and BUSY_D, with at most one memory transaction outstanding.
REQ-015 SHALL, in IDLE, select data when data_req_in=1, unless starve_cnt==STARVE_LIMIT and instr_req_in=1, in which case it selects instr; with only one request present, that request is selected.
REQ-016 SHALL, in IDLE with any request present, drive mem_req_o=1 and drive mem_add_o, mem_we_o, mem_be_o and mem_wdata_o combinationally from the selected requester.
REQ-017 SHALL, for an instr selection, drive mem_we_o=0, mem_be_o=4'b1111 and mem_wdata_o=0.
REQ-018 SHALL, in IDLE with mem_gnt_in=1, assert the selected requester's gnt combinationally in the same cycle, then move to BUSY_I or BUSY_D at the next edge.
REQ-019 SHALL assert no requester gnt when mem_gnt_in=0; requesters hold their request fields until granted.
REQ-020 SHALL, in BUSY_x, drive mem_req_o=0 and all requester gnts=0.
REQ-021 SHALL, in BUSY_x with mem_rvalid_in=1, forward rvalid and mem_rdata_in to the owner in the same cycle and return to IDLE at the next edge.
REQ-022 SHALL deliver a response for writes as well; data_rdata_o is don't-care on a write response.
REQ-023 SHALL hold every non-owner rvalid at 0 and every non-owner rdata at 0.
REQ-024 SHALL perform no new arbitration in the cycle a response returns; minimum spacing is grant, then response, then IDLE.
REQ-025 SHALL ignore mem_rvalid_in in IDLE (stray or late response): nothing forwarded, no state change.
REQ-026 SHALL update starve_cnt as follows:
- increment, saturating at STARVE_LIMIT, on a data grant while instr_req_in=1;
- clear to 0 on an instr grant;
- hold otherwise.
REQ-027 SHALL treat STARVE_LIMIT=0 as instr-always-priority.
REQ-028 SHALL use the fixed priority of REQ-015 when both requests rise in the same cycle.

Reset
REQ-029 SHALL, while reset=1, force state=IDLE, starve_cnt=0, and every output to 0 (mem_req_o, all gnts, rvalids, rdata, mem_add_o, mem_we_o, mem_be_o, mem_wdata_o).
REQ-030 SHALL, on reset mid-transaction, abandon the outstanding transaction; the late mem_rvalid_in after reset release is dropped per REQ-025.
REQ-031 SHALL accept requests on the first rising edge after reset deasserts.

Verification
REQ-032 Instr only: instr_req_in=1, instr_addr_in=0x10, mem_gnt_in=1, and mem_rvalid_in=1 with mem_rdata_in=0x00100093 one cycle later -> instr_gnt_o=1 in cycle 0; instr_rvalid_o=1 with instr_rdata_o=0x00100093 in cycle 1; data_rvalid_o=0 throughout.
REQ-033 Data write: data_req_in=1, data_we_in=1, data_add_in=0x200, data_be_in=4'b0011, data_wdata_in=0xCAFE -> mem_add_o=0x200, mem_we_o=1, mem_be_o=4'b0011 and data_gnt_o=1; the response produces data_rvalid_o=1.
REQ-034 Contention with STARVE_LIMIT=3: both requests held, memory grant every cycle with 1-cycle responses -> grant order D,D,D,I,D,D,D,I; starve_cnt sequence 1,2,3,0.
REQ-035 Grant stall: mem_gnt_in=0 for 5 cycles with data_req_in=1 -> mem_req_o=1 and data_gnt_o=0 for all 5 cycles; data_gnt_o rises in the cycle mem_gnt_in=1.
REQ-036 Reset in BUSY_D: assert reset after a data grant, then deliver mem_rvalid_in=1 after release -> data_rvalid_o=0 and state=IDLE.
REQ-037 Stray response: mem_rvalid_in=1 in IDLE with no requests -> both rvalids=0 and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch (instr) and LSU (data) share one port.
// One transaction outstanding; data wins unless instr has starved too long.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        req,
    input  logic        reset,
    input  logic        instr_req_in,
    input  logic [31:0] instr_addr_in,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_in,
    input  logic [31:0] data_add_in,
    input  logic        data_we_in,
    input  logic [3:0]  data_be_in,
    input  logic [31:0] data_wdata_in,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_add_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_in,
    input  logic        mem_rvalid_in,
    input  logic [31:0] mem_rdata_in
);

    localparam int unsigned CW =
        (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;
    logic            any_req;
    logic            sel_instr;
    logic            grant;

    assign any_req   = instr_req_in | data_req_in;
    assign sel_instr = instr_req_in &
                       (~data_req_in | (starve_cnt == LIMIT));
    assign grant     = (state == IDLE) & any_req & mem_gnt_in;

    // State and starvation counter registers.
    always_ff @(posedge req or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Next state: leave IDLE on a grant, return on the response.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (sel_instr) begin
                        state_nxt  = BUSY_I;
                        starve_nxt = '0;
                    end else begin
                        state_nxt = BUSY_D;
                        if (instr_req_in && starve_cnt != LIMIT)
                            starve_nxt = starve_cnt + 1'b1;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_rvalid_in)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: request mux in IDLE, response routing while busy.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_add_o      = '0;
        mem_we_o       = 1'b0;
        mem_be_o       = '0;
        mem_wdata_o    = '0;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = '0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_req_o = 1'b1;
                        if (sel_instr) begin
                            mem_add_o   = instr_addr_in;
                            mem_be_o    = 4'b1111;
                            instr_gnt_o = mem_gnt_in;
                        end else begin
                            mem_add_o   = data_add_in;
                            mem_we_o    = data_we_in;
                            mem_be_o    = data_be_in;
                            mem_wdata_o = data_wdata_in;
                            data_gnt_o  = mem_gnt_in;
                        end
                    end
                end
                BUSY_I: begin
                    instr_rvalid_o = mem_rvalid_in;
                    if (mem_rvalid_in)
                        instr_rdata_o = mem_rdata_in;
                end
                BUSY_D: begin
                    data_rvalid_o = mem_rvalid_in;
                    if (mem_rvalid_in)
                        data_rdata_o = mem_rdata_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: combinational IDLE vectors from a table,
// then hand-written grant/response, stall, contention and reset sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ir;
    logic [31:0] ia;
    logic        igo;
    logic        ivo;
    logic [31:0] ido;
    logic        dr;
    logic [31:0] da;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic        dgo;
    logic        dvo;
    logic [31:0] ddo;
    logic        mreq;
    logic [31:0] madd;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] mwd;
    logic        mgnt;
    logic        mrv;
    logic [31:0] mrd;

    logic        z_igo;
    logic        z_ivo;
    logic [31:0] z_ido;
    logic        z_dgo;
    logic        z_dvo;
    logic [31:0] z_ddo;
    logic        z_mreq;
    logic [31:0] z_madd;
    logic        z_mwe;
    logic [3:0]  z_mbe;
    logic [31:0] z_mwd;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .req(clk), .reset(rst),
        .instr_req_in(ir), .instr_addr_in(ia),
        .instr_gnt_o(igo), .instr_rvalid_o(ivo),
        .instr_rdata_o(ido),
        .data_req_in(dr), .data_add_in(da), .data_we_in(dwe),
        .data_be_in(dbe), .data_wdata_in(dwd),
        .data_gnt_o(dgo), .data_rvalid_o(dvo), .data_rdata_o(ddo),
        .mem_req_o(mreq), .mem_add_o(madd), .mem_we_o(mwe),
        .mem_be_o(mbe), .mem_wdata_o(mwd),
        .mem_gnt_in(mgnt), .mem_rvalid_in(mrv), .mem_rdata_in(mrd)
    );

    mem_arbiter #(.STARVE_LIMIT(0)) u0 (
        .req(clk), .reset(rst),
        .instr_req_in(ir), .instr_addr_in(ia),
        .instr_gnt_o(z_igo), .instr_rvalid_o(z_ivo),
        .instr_rdata_o(z_ido),
        .data_req_in(dr), .data_add_in(da), .data_we_in(dwe),
        .data_be_in(dbe), .data_wdata_in(dwd),
        .data_gnt_o(z_dgo), .data_rvalid_o(z_dvo), .data_rdata_o(z_ddo),
        .mem_req_o(z_mreq), .mem_add_o(z_madd), .mem_we_o(z_mwe),
        .mem_be_o(z_mbe), .mem_wdata_o(z_mwd),
        .mem_gnt_in(mgnt), .mem_rvalid_in(mrv), .mem_rdata_in(mrd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwd;
        logic        mrv;
        logic        mreq;
        logic [31:0] madd;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] mwd;
        logic [31:0] add0;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ir = 1'b0; ia = '0; dr = 1'b0; da = '0; dwe = 1'b0;
        dbe = '0; dwd = '0; mgnt = 1'b0; mrv = 1'b0; mrd = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_g [8];
    logic [1:0] exp_c [8];

    initial begin
        tbl[0] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1,
                   1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 4'h3, 32'h5555, 1'b0,
                   1'b1, 32'h10, 1'b0, 4'hf, 32'h0, 32'h10};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 4'h3, 32'hcafe, 1'b1,
                   1'b1, 32'h200, 1'b1, 4'h3, 32'hcafe, 32'h200};
        tbl[3] = '{1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 4'hf, 32'h1234, 1'b0,
                   1'b1, 32'h300, 1'b0, 4'hf, 32'h1234, 32'h40};
        tbl[4] = '{1'b1, 32'h44, 1'b1, 32'h304, 1'b1, 4'hc, 32'hbeef, 1'b1,
                   1'b1, 32'h304, 1'b1, 4'hc, 32'hbeef, 32'h44};
        // {instr_gnt, data_gnt} per grant, and starve_cnt after it
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset with requests and grant present: all outputs held low
        idle_inputs();
        rst = 1'b1;
        ir = 1'b1; ia = 32'h80; dr = 1'b1; da = 32'h90;
        dwe = 1'b1; dbe = 4'hf; dwd = 32'h77; mgnt = 1'b1;
        mrv = 1'b1; mrd = 32'h99;
        @(negedge clk);
        chk("rst_mreq", 32'(mreq), 32'd0);
        chk("rst_add", madd, 32'h0);
        chk("rst_we_be", {27'b0, mwe, mbe}, 32'd0);
        chk("rst_wdata", mwd, 32'h0);
        chk("rst_gnts", {30'b0, igo, dgo}, 32'd0);
        chk("rst_rvalids", {30'b0, ivo, dvo}, 32'd0);
        chk("rst_rdata", ido | ddo, 32'h0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();

        // Combinational IDLE vectors (no grant, so state stays IDLE)
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            ir = tbl[i].ir; ia = tbl[i].ia;
            dr = tbl[i].dr; da = tbl[i].da;
            dwe = tbl[i].dwe; dbe = tbl[i].dbe; dwd = tbl[i].dwd;
            mrv = tbl[i].mrv; mrd = 32'hdead0000 + i;
            mgnt = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_mreq", i), 32'(mreq), 32'(tbl[i].mreq));
            chk($sformatf("v%0d_add", i), madd, tbl[i].madd);
            chk($sformatf("v%0d_we", i), 32'(mwe), 32'(tbl[i].mwe));
            chk($sformatf("v%0d_be", i), 32'(mbe), 32'(tbl[i].mbe));
            chk($sformatf("v%0d_wdata", i), mwd, tbl[i].mwd);
            chk($sformatf("v%0d_gnts", i), {30'b0, igo, dgo}, 32'd0);
            chk($sformatf("v%0d_rvalids", i), {30'b0, ivo, dvo}, 32'd0);
            chk($sformatf("v%0d_lim0_add", i), z_madd, tbl[i].add0);
        end

        // Instr only: grant, then response one cycle later
        next_cycle();
        idle_inputs();
        ir = 1'b1; ia = 32'h10; mgnt = 1'b1;
        @(negedge clk);
        chk("i_gnt", 32'(igo), 32'd1);
        chk("i_dgnt", 32'(dgo), 32'd0);
        chk("i_add", madd, 32'h10);
        next_cycle();
        ir = 1'b0; mgnt = 1'b0; mrv = 1'b1; mrd = 32'h00100093;
        @(negedge clk);
        chk("i_rvalid", 32'(ivo), 32'd1);
        chk("i_rdata", ido, 32'h00100093);
        chk("i_d_rvalid", 32'(dvo), 32'd0);
        chk("i_d_rdata", ddo, 32'h0);
        chk("i_busy_mreq", 32'(mreq), 32'd0);

        // Data write: fields routed, response delivered to LSU
        next_cycle();
        idle_inputs();
        dr = 1'b1; dwe = 1'b1; da = 32'h200; dbe = 4'b0011;
        dwd = 32'hcafe; mgnt = 1'b1;
        @(negedge clk);
        chk("w_add", madd, 32'h200);
        chk("w_we", 32'(mwe), 32'd1);
        chk("w_be", 32'(mbe), 32'h3);
        chk("w_wdata", mwd, 32'hcafe);
        chk("w_gnt", 32'(dgo), 32'd1);
        next_cycle();
        dr = 1'b0; mgnt = 1'b0; mrv = 1'b1; mrd = 32'h0;
        @(negedge clk);
        chk("w_rvalid", 32'(dvo), 32'd1);
        chk("w_i_rvalid", 32'(ivo), 32'd0);

        // Grant stall: request held five cycles without mem grant
        next_cycle();
        idle_inputs();
        dr = 1'b1; da = 32'h400; dbe = 4'hf;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_mreq", k), 32'(mreq), 32'd1);
            chk($sformatf("stall%0d_gnt", k), 32'(dgo), 32'd0);
            next_cycle();
        end
        mgnt = 1'b1;
        @(negedge clk);
        chk("stall_gnt", 32'(dgo), 32'd1);
        next_cycle();
        dr = 1'b0; mgnt = 1'b0; mrv = 1'b1; mrd = 32'h5a5a;
        @(negedge clk);
        chk("stall_rdata", ddo, 32'h5a5a);

        // Contention: both held, grant and response every cycle
        next_cycle();
        idle_inputs();
        ir = 1'b1; ia = 32'h1000; dr = 1'b1; da = 32'h2000;
        dbe = 4'hf; mgnt = 1'b1; mrv = 1'b1; mrd = 32'h1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("cont%0d_gnt", k), {30'b0, igo, dgo},
                {30'b0, exp_g[k]});
            @(negedge clk);
            chk($sformatf("cont%0d_cnt", k), 32'(dut.starve_cnt),
                {30'b0, exp_c[k]});
            chk($sformatf("cont%0d_rv", k), {30'b0, ivo, dvo},
                {30'b0, exp_g[k]});
        end

        // Reset in BUSY_D abandons the transaction
        next_cycle();
        idle_inputs();
        ir = 1'b1; ia = 32'h20; dr = 1'b1; da = 32'h600;
        dbe = 4'hf; mgnt = 1'b1;
        @(negedge clk);
        chk("rb_gnt", {30'b0, igo, dgo}, 32'd1);
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("rb_cnt", 32'(dut.starve_cnt), 32'd0);
        chk("rb_out", {30'b0, ivo, dvo}, 32'd0);
        next_cycle();
        rst = 1'b0;
        mrv = 1'b1; mrd = 32'hbad0;
        @(negedge clk);
        chk("rb_late_rv", {30'b0, ivo, dvo}, 32'd0);
        chk("rb_late_rdata", ddo, 32'h0);
        next_cycle();
        mrv = 1'b0; dr = 1'b1; da = 32'h700; dbe = 4'hf; mgnt = 1'b1;
        @(negedge clk);
        chk("rb_idle_gnt", 32'(dgo), 32'd1);
        next_cycle();
        idle_inputs();
        mrv = 1'b1;
        @(negedge clk);
        chk("rb_resp", 32'(dvo), 32'd1);

        // Stray response in IDLE: ignored, arbiter stays ready
        next_cycle();
        idle_inputs();
        mrv = 1'b1; mrd = 32'h3333;
        @(negedge clk);
        chk("stray_rv", {30'b0, ivo, dvo}, 32'd0);
        next_cycle();
        mrv = 1'b0; ir = 1'b1; ia = 32'h30; mgnt = 1'b1;
        @(negedge clk);
        chk("stray_then_gnt", 32'(igo), 32'd1);
        next_cycle();
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
